// File: rtl/riscv_encoder.sv
// RISC-V instruction encoder with a 2-entry output FIFO.
// Requests are encoded combinationally and pushed into the FIFO.
// The output side is driven only from registered FIFO state, so
// there is no combinational path from the request inputs to the outputs.
module riscv_encoder #(
  parameter int Bitness = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         op_code,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Bitness-1:0] instruction,
  output logic               err,
  output logic [15:0]        err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [Bitness-1:0] fifo_instr_reg [0:1];
  logic               fifo_err_reg   [0:1];
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic               ready_en_reg;
  logic [15:0]        err_count_reg;

  logic [31:0]        enc_word;
  logic               enc_err;
  logic               accept;
  logic               deliver;

  // Immediate range checks: the upper bits must all be copies of the sign bit.
  logic imm_fits_12;
  logic imm_fits_13;
  logic imm_fits_21;

  assign imm_fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm_fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign imm_fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Ready depends only on registered state; held low until the first edge after reset.
  assign in_ready  = ready_en_reg && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  assign instruction = fifo_instr_reg[rd_ptr_reg];
  assign err         = fifo_err_reg[rd_ptr_reg];
  assign err_count   = err_count_reg;

  // Field packing and legality checks for each instruction format.
  always_comb begin
    enc_word = 32'h0000_0000;
    enc_err  = (op_code[1:0] != 2'b11);
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, op_code};
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, op_code};
        if (!imm_fits_12) enc_err = 1'b1;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op_code};
        if (!imm_fits_12) enc_err = 1'b1;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op_code};
        if (!imm_fits_13 || imm[0]) enc_err = 1'b1;
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, op_code};
        if (imm[11:0] != 12'h000) enc_err = 1'b1;
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_code};
        if (!imm_fits_21 || imm[0]) enc_err = 1'b1;
      end
      default: begin
        enc_word = 32'h0000_0000;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Occupancy after this cycle's accept/deliver pair.
  always_comb begin
    count_next = count_reg;
    case ({accept, deliver})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage: each entry is written when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    // Capture the encoded word and its error flag on accept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fifo_instr_reg[gi] <= '0;
        fifo_err_reg[gi]   <= 1'b0;
      end else if (accept && (wr_ptr_reg == gi[0])) begin
        fifo_instr_reg[gi] <= enc_word[Bitness-1:0];
        fifo_err_reg[gi]   <= enc_err;
      end
    end
  end

  // Pointers, occupancy and post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      ready_en_reg <= 1'b1;
      if (accept)  wr_ptr_reg <= ~wr_ptr_reg;
      if (deliver) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Saturating count of accepted requests that were flagged erroneous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= 16'h0000;
    end else if (accept && enc_err && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'h0001;
    end
  end

endmodule

// File: doc/riscv_encoder.md
RISCV_ENCODER -- requirements
Module: riscv_encoder

Interface
REQ-001 Parameter: Bitness, default 32, instruction width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  encode request valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 illegal.
REQ-007 op_code  input  7  opcode field.
REQ-008 rd, rs1, rs2  input  5 each  register indices.
REQ-009 funct3  input  3  funct3 field; funct7  input  7  funct7 field (R only).
REQ-010 imm  input  32  signed byte-offset/immediate, two's complement.
REQ-011 out_valid  output  1  encoded word available.
REQ-012 out_ready  input  1  consumer accepts word.
REQ-013 instruction  output  Bitness  encoded instruction word.
REQ-014 err  output  1  error flag travelling with instruction.
REQ-015 err_count  output  16  count of accepted requests flagged err.

Function
REQ-016 Accept occurs when in_valid && in_ready; deliver occurs when out_valid && out_ready.
REQ-017 Accepted requests SHALL be encoded and written into a 2-entry FIFO (instruction + err); output comes from FIFO head, registered, in order.
REQ-018 Latency: accept at edge N -> out_valid=1 with that word after edge N if FIFO was empty; no combinational in->out path.
REQ-019 in_ready = (occupancy < 2), registered-state only; no combinational dependence on out_ready.
REQ-020 Full and delivering in same cycle: no accept that cycle; occupancy 2->1.
REQ-021 Accept and deliver in same cycle at occupancy 1: occupancy stays 1, new word becomes head next cycle.
REQ-022 Empty: out_valid=0; instruction holds last value (don't-care for checker).
REQ-023 Encoding bits [6:0]=op_code for all formats; rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20] where the format uses them.
REQ-024 R: funct7[31:25]; I: imm[11:0] at [31:20]; S: imm[11:5] at [31:25], imm[4:0] at [11:7].
REQ-025 B: imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], imm[11] at [7].
REQ-026 U: imm[31:12] at [31:12]; J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12].
REQ-027 err=1 if: fmt>5; op_code[1:0]!=2'b11; I/S imm outside -2048..2047; B imm outside -4096..4094 or imm[0]=1; J imm outside -1048576..1048574 or imm[0]=1; U imm[11:0]!=0.
REQ-028 Erroneous requests SHALL still be accepted and encoded with truncated fields; fmt>5 SHALL encode 32'h00000000.
REQ-029 err_count increments by 1 per accepted erroneous request, saturating at 16'hFFFF.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) flush the FIFO: occupancy=0, out_valid=0, in_ready=0 while asserted, instruction=0, err=0, err_count=0.
REQ-031 in_ready=1 on first edge after rst_n deassertion; reset mid-transfer discards all pending words without delivery.

Verification
REQ-032 I fmt, op 0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> next cycle instruction=0x00500093, err=0.
REQ-033 R op 0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> 0x002081B3; S op 0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
REQ-034 B op 0x63, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463; U op 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-035 I imm=2048 -> err=1, err_count=1; B imm=6... with imm=7 -> err=1, err_count=2; fmt=7 -> instruction=0, err=1.
REQ-036 out_ready=0, in_valid=1 for 3 cycles -> 2 accepted, in_ready=0 third cycle; then out_ready=1 -> two words in order, in_ready=1 next cycle.
REQ-037 Reset asserted with occupancy 2 -> out_valid=0 same cycle, err_count=0; no stale word after release.
